// File: rtl/ram_march_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_march_bist_ctrl_if
// Brief    : Control/status and RAM-port bundle for the March C BIST controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_march_bist_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [DATA_W-1:0] pattern;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  fail_count;
    logic [ADDR_W-1:0] first_fail_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // master: the BIST controller; slave: register block plus the RAM it owns
    modport master (
        input  start, pattern, mem_dout,
        output busy, done, pass, fail_count, first_fail_addr,
        output mem_we, mem_addr, mem_din
    );

    modport slave (
        output start, pattern, mem_dout,
        input  busy, done, pass, fail_count, first_fail_addr,
        input  mem_we, mem_addr, mem_din
    );
endinterface
`default_nettype wire

// File: rtl/ram_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_march_bist_ctrl
// Brief    : March C-style self-test initiator for a registered-read RAM port.
// Revision : 1.0 - initial release
// ============================================================================
module ram_march_bist_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 32768,
    parameter int CNT_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ram_march_bist_ctrl_if.master  bus
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_W0    = 3'd1,
        S_R0    = 3'd2,
        S_W1    = 3'd3,
        S_R1    = 3'd4,
        S_DRAIN = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_pat;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [CNT_W-1:0]  r_failCnt;
    logic [ADDR_W-1:0] r_firstFail;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_cmpValid;
    logic [ADDR_W-1:0] r_cmpAddr;

    logic              w_chk;
    logic [DATA_W-1:0] w_expData;
    logic [ADDR_W-1:0] w_chkAddr;
    logic              w_mismatch;
    logic [CNT_W-1:0]  w_failNext;

    // W1 checks the read issued by the preceding R0 at the same address;
    // R1/DRAIN check the read issued one cycle earlier, tracked in r_cmpAddr.
    always_comb begin
        w_chk     = 1'b0;
        w_expData = r_pat;
        w_chkAddr = r_addr;
        if (r_state == S_W1) begin
            w_chk = 1'b1;
        end else if ((r_state == S_R1) || (r_state == S_DRAIN)) begin
            w_chk     = r_cmpValid;
            w_expData = ~r_pat;
            w_chkAddr = r_cmpAddr;
        end
    end

    assign w_mismatch = w_chk && (bus.mem_dout != w_expData);
    assign w_failNext = (w_mismatch && (r_failCnt != c_CNT_MAX))
                      ? r_failCnt + CNT_W'(1) : r_failCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pat       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_failCnt   <= '0;
            r_firstFail <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_cmpValid  <= 1'b0;
            r_cmpAddr   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_cmpValid <= 1'b0;
            if (w_mismatch) begin
                r_failCnt <= w_failNext;
                if (r_failCnt == '0) begin
                    r_firstFail <= w_chkAddr;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pat       <= bus.pattern;
                        r_failCnt   <= '0;
                        r_firstFail <= '0;
                        r_pass      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_we        <= 1'b1;
                        r_addr      <= '0;
                        r_din       <= bus.pattern;
                        r_state     <= S_W0;
                    end
                end
                S_W0: begin
                    if (r_addr == c_LAST_ADDR) begin
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_state <= S_R0;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                S_R0: begin
                    r_we    <= 1'b1;
                    r_din   <= ~r_pat;
                    r_state <= S_W1;
                end
                S_W1: begin
                    r_we <= 1'b0;
                    if (r_addr == c_LAST_ADDR) begin
                        r_state <= S_R1;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_R0;
                    end
                end
                S_R1: begin
                    r_cmpValid <= 1'b1;
                    r_cmpAddr  <= r_addr;
                    if (r_addr == '0) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr - ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_failNext == '0);
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.fail_count      = r_failCnt;
    assign bus.first_fail_addr = r_firstFail;
    assign bus.mem_we          = r_we;
    assign bus.mem_addr        = r_addr;
    assign bus.mem_din         = r_din;

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_march_bist_ctrl
// Brief    : Scoreboard bench for ram_march_bist_ctrl with a faultable RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_march_bist_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 2;
    localparam int BUSY_LEN = 4 * DEPTH + 1;

    typedef struct {
        logic [DATA_W-1:0] pat;
        logic              pass;
        logic [CNT_W-1:0]  cnt;
        logic [ADDR_W-1:0] ffa;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   doneCount = 0;
    int   faultMode = 0;
    exp_t q[$];

    logic [DATA_W-1:0] ram [DEPTH];

    always #5 clk = ~clk;

    ram_march_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    ram_march_bist_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Mode 1: addr 5 bit2 stuck-1; mode 2: addr 3 bit0 stuck-0; mode 3: all reads 0
    function automatic logic [DATA_W-1:0] faulty(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (faultMode == 1 && a == ADDR_W'(5)) r = d | 4'b0100;
        if (faultMode == 2 && a == ADDR_W'(3)) r = d & 4'b1110;
        if (faultMode == 3) r = '0;
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
        else            bus.mem_dout <= faulty(bus.mem_addr, ram[bus.mem_addr]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected RAM-port activity on busy cycle k of a test with pattern p
    task automatic expSeq(input int k, input logic [DATA_W-1:0] p, output logic we,
                          output logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
        int j;
        we = 1'b0; a = '0; d = p;
        if (k < DEPTH) begin
            we = 1'b1; a = ADDR_W'(k);
        end else if (k < 3 * DEPTH) begin
            j = k - DEPTH;
            a = ADDR_W'(j / 2); we = (j % 2) == 1; d = ~p;
        end else if (k < 4 * DEPTH) begin
            a = ADDR_W'(DEPTH - 1 - (k - 3 * DEPTH));
        end
    endtask

    // Monitor: checks port activity every busy cycle, scores each done pulse
    always @(negedge clk) begin : mon
        static int busyCyc = 0;
        static int seqErr  = 0;
        logic              ew;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        exp_t              e;
        int                ramErr;
        if (bus.busy) begin
            if (q.size() > 0) begin
                expSeq(busyCyc, q[0].pat, ew, ea, ed);
                if (busyCyc >= BUSY_LEN || bus.mem_we !== ew || bus.mem_addr !== ea
                    || (ew && bus.mem_din !== ed)) seqErr++;
            end
            busyCyc++;
        end else if (bus.done) begin
            doneCount++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                ramErr = 0;
                for (int i = 0; i < DEPTH; i++) if (ram[i] !== ~e.pat) ramErr++;
                chk("pass", 32'(bus.pass), 32'(e.pass));
                chk("fail_count", 32'(bus.fail_count), 32'(e.cnt));
                chk("first_fail_addr", 32'(bus.first_fail_addr), 32'(e.ffa));
                chk("busy_cycles", 32'(busyCyc), 32'(BUSY_LEN));
                chk("port_sequence_errors", 32'(seqErr), 32'd0);
                chk("ram_final_errors", 32'(ramErr), 32'd0);
            end
            busyCyc = 0; seqErr = 0;
        end else begin
            busyCyc = 0; seqErr = 0;
        end
    end

    task automatic push(input logic [DATA_W-1:0] p, input logic ps,
                        input logic [CNT_W-1:0] c, input logic [ADDR_W-1:0] f);
        exp_t e;
        e.pat = p; e.pass = ps; e.cnt = c; e.ffa = f;
        q.push_back(e);
    endtask

    task automatic startTest(input logic [DATA_W-1:0] p);
        @(negedge clk);
        bus.pattern = p;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int  n = 0;
        logic seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] allOut();
        return 32'({bus.busy, bus.done, bus.pass, bus.fail_count, bus.first_fail_addr,
                    bus.mem_we, bus.mem_addr, bus.mem_din});
    endfunction

    initial begin : stim
        int d0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.pattern = '0;
        repeat (3) @(negedge clk);
        chk("outputs_in_reset", allOut(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("outputs_idle_after_reset", allOut(), 32'd0);

        faultMode = 0; push(4'hA, 1'b1, 2'd0, 4'd0); startTest(4'hA); waitDone("done_ideal");
        faultMode = 1; push(4'hA, 1'b0, 2'd1, 4'd5); startTest(4'hA); waitDone("done_r0_fault");
        faultMode = 2; push(4'hA, 1'b0, 2'd1, 4'd3); startTest(4'hA); waitDone("done_r1_fault");
        faultMode = 3; push(4'hF, 1'b0, 2'd3, 4'd0); startTest(4'hF); waitDone("done_saturate");

        // Abort mid-W1 at address 7, then rerun a clean test
        faultMode = 0;
        push(4'hA, 1'b1, 2'd0, 4'd0);
        startTest(4'hA);
        repeat (2 * DEPTH - 1) @(negedge clk);
        chk("mid_w1_addr", 32'(bus.mem_addr), 32'd7);
        chk("mid_w1_we", 32'(bus.mem_we), 32'd1);
        #1 rst = 1'b1;
        #1 chk("outputs_async_reset", allOut(), 32'd0);
        q.delete(0);
        @(negedge clk);
        rst = 1'b0;
        push(4'h3, 1'b1, 2'd0, 4'd0); startTest(4'h3); waitDone("done_after_abort");

        // start held high: exactly three back-to-back tests in 200 cycles
        for (int i = 0; i < 3; i++) push(4'h6, 1'b1, 2'd0, 4'd0);
        d0 = doneCount;
        @(negedge clk);
        bus.pattern = 4'h6;
        bus.start   = 1'b1;
        repeat (200) @(negedge clk);
        bus.start   = 1'b0;
        repeat (80) @(negedge clk);
        chk("held_start_done_pulses", 32'(doneCount - d0), 32'd3);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ram_march_bist_ctrl.md
Name: ram_march_bist_ctrl

Overview:
- Single-clock initiator that drives one port of the team's single-port-per-clock RAM macros (we/addr/din/dout, registered read, read-or-write per cycle).
- Runs a March C-style self-test over every address: write a pattern, read/verify and write its complement, then read/verify in descending order.
- Reports pass/fail, a saturating mismatch count and the first failing address.
- Sits between the test/debug register block and the RAM port it owns during test.

Parameters:
- ADDR_W, 15, address width of the RAM port.
- DATA_W, 4, data width of the RAM port.
- DEPTH, 32768, number of words tested (addresses 0..DEPTH-1, DEPTH <= 2**ADDR_W).
- CNT_W, 16, width of the saturating mismatch counter.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled request; accepted only in IDLE.
- pattern  in  DATA_W  background pattern P; captured when start is accepted.
- busy  out  1  high while a test is in progress.
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  1 if fail_count==0; valid from done until the next accepted start.
- fail_count  out  CNT_W  mismatch count, saturates at all-ones.
- first_fail_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data, valid the cycle after a read (mem_we=0) is issued.

Behaviour:
- Reset (async, any state, including mid-test): state=IDLE. busy, done, pass, fail_count, first_fail_addr, mem_we, mem_addr and mem_din all = 0. Captured P = 0.
- All outputs are registered.
- States: IDLE, W0, R0, W1, R1, DRAIN, DONE.
- IDLE: if start=1, capture P, clear fail_count and first_fail_addr, pass=0, set addr=0, go to W0. start is ignored in every other state.
- W0 (ascending): mem_we=1, mem_din=P, one address per cycle. After DEPTH-1, set addr=0 and go to R0.
- R0 (ascending): mem_we=0 (read addr), then go to W1.
- W1: same addr, mem_we=1, mem_din=~P. In the same cycle compare mem_dout against P (the read issued in R0). After the last address, set addr=DEPTH-1 and go to R1; otherwise addr+1 and return to R0.
- R1 (descending): mem_we=0, one read per cycle. Each cycle compares the previous R1 read's data against ~P. After addr 0, go to DRAIN.
- DRAIN: compare the final read (addr 0) against ~P, mem_we=0, then go to DONE.
- DONE: busy=0, done=1 for exactly this cycle, pass=(fail_count==0), return to IDLE.
- Any compare that sees a mismatch:
  - increments fail_count, saturating at 2**CNT_W-1 (no wrap);
  - if it is the first mismatch, records the address of the read being checked into first_fail_addr.
- busy is high from the cycle after start is accepted through DRAIN: exactly 4*DEPTH+1 cycles. done occurs in the following cycle.
- mem_we is 0 and mem_addr/mem_din hold their last value in IDLE and DONE.
- Address counter width is ADDR_W. No wrap occurs beyond DEPTH-1 or below 0, because phase transitions fire at the terminal address.
- A start held high through DONE starts a new test on the next IDLE cycle.
- Compare data is only the mem_dout sampled in the cycle after a read; the cycle after a write is never compared.

Test Plan:
- DEPTH=16, ADDR_W=4, ideal RAM model, P=4'hA, start pulse -> busy high exactly 65 cycles; mem_addr sequence 0..15 (W0), 0,0,1,1..15,15 (R0/W1), 15..0 (R1); done one pulse; pass=1, fail_count=0, first_fail_addr=0; final RAM contents all 4'h5.
- Same config, model with addr 5 bit2 stuck-at-1, P=4'hA -> R0 compare fails at addr 5 only; fail_count=1, first_fail_addr=5, pass=0.
- Model with addr 3 bit0 stuck-at-0, P=4'hA -> R1 compare fails at addr 3 only; fail_count=1, first_fail_addr=3, pass=0.
- CNT_W=2, all words stuck at 4'h0, P=4'hF -> fail_count saturates at 3; first_fail_addr=0 (first R0 compare), pass=0.
- Assert rst for 1 cycle mid-W1 at addr 7 -> all outputs 0 immediately (async); then a new start with P=4'h3 runs a full 65-cycle test and returns pass=1.
- start held high for 200 cycles -> start ignored while busy; three back-to-back tests, each 65 busy cycles plus one DONE cycle, three done pulses.
